// File: rtl/alu_pkg.sv
// Shared opcode encodings and default geometry for the execute-stage ALU.
// Pure definitions; no logic, no latency.
// No flow control; consumers sample every cycle.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_BLOCK = 4;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NAND = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_XNOR = 4'd8;
    localparam logic [3:0] OP_NOT  = 4'd9;
    localparam logic [3:0] OP_SLL  = 4'd10;
    localparam logic [3:0] OP_SRL  = 4'd11;
    localparam logic [3:0] OP_SRA  = 4'd12;
    localparam logic [3:0] OP_SLT  = 4'd13;
    localparam logic [3:0] OP_INC  = 4'd14;
    localparam logic [3:0] OP_PASS = 4'd15;

endpackage

// File: rtl/csla_adder.sv
// Carry-select adder: ripple first block, dual-precomputed later blocks muxed by carry.
// Purely combinational, zero cycles.
// No flow control.
module csla_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int BLOCK = ALU_BLOCK
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NBLK = WIDTH / BLOCK;

    logic [NBLK:0] carry;

    assign carry[0] = cin;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        logic [BLOCK-1:0] a_blk;
        logic [BLOCK-1:0] b_blk;

        assign a_blk = a[g*BLOCK +: BLOCK];
        assign b_blk = b[g*BLOCK +: BLOCK];

        if (g == 0) begin : g_ripple
            logic [BLOCK:0] s;
            assign s = {1'b0, a_blk} + {1'b0, b_blk} + {{BLOCK{1'b0}}, carry[0]};
            assign sum[BLOCK-1:0] = s[BLOCK-1:0];
            assign carry[1]       = s[BLOCK];
        end else begin : g_select
            // Both carry-in cases are ready before the lower carry arrives.
            logic [BLOCK:0] s0;
            logic [BLOCK:0] s1;
            assign s0 = {1'b0, a_blk} + {1'b0, b_blk};
            assign s1 = {1'b0, a_blk} + {1'b0, b_blk} + {{BLOCK{1'b0}}, 1'b1};
            assign sum[g*BLOCK +: BLOCK] = carry[g] ? s1[BLOCK-1:0] : s0[BLOCK-1:0];
            assign carry[g+1]            = carry[g] ? s1[BLOCK]     : s0[BLOCK];
        end
    end

    assign cout = carry[NBLK];

endmodule

// File: rtl/alu_1.sv
// Execute-stage 16-op ALU with full-width multiply product output.
// Latency 1 cycle, one op accepted every cycle.
// No backpressure: inputs are sampled unconditionally on every clk edge.
module alu_1
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int BLOCK = ALU_BLOCK
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   operand1,
    input  logic [WIDTH-1:0]   operand2,
    input  logic [3:0]         opcode,
    output logic [WIDTH-1:0]   result,
    output logic               carry_out,
    output logic [2*WIDTH-1:0] product
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0]   add_b;
    logic               add_cin;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [2*WIDTH-1:0] mul_full;
    logic [SHW-1:0]     shamt;

    logic [WIDTH-1:0]   result_d,  result_q;
    logic               carry_d,   carry_q;
    logic [2*WIDTH-1:0] product_d, product_q;

    // SUB is A + ~B + 1 and INC is A + 0 + 1, sharing the one adder.
    always_comb begin
        add_b   = operand2;
        add_cin = 1'b0;
        if (opcode == OP_SUB) begin
            add_b   = ~operand2;
            add_cin = 1'b1;
        end else if (opcode == OP_INC) begin
            add_b   = '0;
            add_cin = 1'b1;
        end
    end

    csla_adder #(
        .WIDTH (WIDTH),
        .BLOCK (BLOCK)
    ) u_csla (
        .a    (operand1),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign mul_full = {{WIDTH{1'b0}}, operand1} * {{WIDTH{1'b0}}, operand2};
    assign shamt    = operand2[SHW-1:0];

    always_comb begin
        result_d  = '0;
        carry_d   = 1'b0;
        product_d = '0;
        case (opcode)
            OP_ADD:  begin result_d = add_sum; carry_d = add_cout;  end
            OP_SUB:  begin result_d = add_sum; carry_d = ~add_cout; end
            OP_MUL:  begin product_d = mul_full; result_d = mul_full[WIDTH-1:0]; end
            OP_AND:  result_d = operand1 & operand2;
            OP_OR:   result_d = operand1 | operand2;
            OP_XOR:  result_d = operand1 ^ operand2;
            OP_NAND: result_d = ~(operand1 & operand2);
            OP_NOR:  result_d = ~(operand1 | operand2);
            OP_XNOR: result_d = ~(operand1 ^ operand2);
            OP_NOT:  result_d = ~operand1;
            OP_SLL:  result_d = operand1 << shamt;
            OP_SRL:  result_d = operand1 >> shamt;
            OP_SRA:  result_d = $unsigned($signed(operand1) >>> shamt);
            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
            OP_INC:  begin result_d = add_sum; carry_d = add_cout;  end
            OP_PASS: result_d = operand1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q  <= '0;
            carry_q   <= 1'b0;
            product_q <= '0;
        end else begin
            result_q  <= result_d;
            carry_q   <= carry_d;
            product_q <= product_d;
        end
    end

    assign result    = result_q;
    assign carry_out = carry_q;
    assign product   = product_q;

endmodule

// File: tb/tb_alu_1.sv
// Scoreboard bench for alu_1: expectations queued at drive time, popped one cycle later.
module tb_alu_1;

    logic        clk;
    logic        rst_n;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [3:0]  opcode;
    logic [31:0] result;
    logic        carry_out;
    logic [63:0] product;

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic [63:0] p;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    alu_1 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .operand1  (operand1),
        .operand2  (operand2),
        .opcode    (opcode),
        .result    (result),
        .carry_out (carry_out),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        exp_t        e;
        logic [32:0] s;
        e.r = '0; e.c = 1'b0; e.p = '0; e.tag = $sformatf("rnd op%0d", op);
        case (op)
            4'd0:  begin s = {1'b0, a} + {1'b0, b}; e.r = s[31:0]; e.c = s[32]; end
            4'd1:  begin e.r = a - b; e.c = (a < b); end
            4'd2:  begin e.p = {32'd0, a} * {32'd0, b}; e.r = e.p[31:0]; end
            4'd3:  e.r = a & b;
            4'd4:  e.r = a | b;
            4'd5:  e.r = a ^ b;
            4'd6:  e.r = ~(a & b);
            4'd7:  e.r = ~(a | b);
            4'd8:  e.r = ~(a ^ b);
            4'd9:  e.r = ~a;
            4'd10: e.r = a << b[4:0];
            4'd11: e.r = a >> b[4:0];
            4'd12: e.r = $unsigned($signed(a) >>> b[4:0]);
            4'd13: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd14: begin s = {1'b0, a} + 33'd1; e.r = s[31:0]; e.c = s[32]; end
            default: e.r = a;
        endcase
        return e;
    endfunction

    task automatic compare_head();
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_val({e.tag, " result"}, {32'd0, result}, {32'd0, e.r});
            check_val({e.tag, " carry"},  {63'd0, carry_out}, {63'd0, e.c});
            check_val({e.tag, " product"}, product, e.p);
        end
    endtask

    // One op per cycle: check what the previous edge registered, then drive the next.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input exp_t e);
        @(negedge clk);
        compare_head();
        operand1 = a;
        operand2 = b;
        opcode   = op;
        exp_q.push_back(e);
    endtask

    task automatic drive_dir(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                             input logic [31:0] r, input logic c, input logic [63:0] p, input string tag);
        exp_t e;
        e.r = r; e.c = c; e.p = p; e.tag = tag;
        drive(a, b, op, e);
    endtask

    logic [31:0] sweep_r [16];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sweep_r = '{32'd16, 32'd0, 32'd64, 32'd8, 32'd8, 32'd0, 32'hFFFFFFF7, 32'hFFFFFFF7,
                    32'hFFFFFFFF, 32'hFFFFFFF7, 32'h800, 32'd0, 32'd0, 32'd0, 32'd9, 32'd8};

        rst_n    = 1'b0;
        operand1 = 32'd8;
        operand2 = 32'd8;
        opcode   = 4'd0;
        repeat (3) @(negedge clk);
        check_val("reset result",  {32'd0, result}, 64'd0);
        check_val("reset carry",   {63'd0, carry_out}, 64'd0);
        check_val("reset product", product, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            drive_dir(32'd8, 32'd8, 4'(i), sweep_r[i], 1'b0, (i == 2) ? 64'd64 : 64'd0,
                      $sformatf("sweep op%0d", i));

        drive_dir(32'hFFFFFFFF, 32'd1, 4'd0, 32'd0, 1'b1, 64'd0, "add wrap");
        drive_dir(32'd3, 32'd5, 4'd1, 32'hFFFFFFFE, 1'b1, 64'd0, "sub 3-5");
        drive_dir(32'd0, 32'd1, 4'd1, 32'hFFFFFFFF, 1'b1, 64'd0, "sub 0-1");
        drive_dir(32'hFFFFFFFF, 32'd7, 4'd14, 32'd0, 1'b1, 64'd0, "inc wrap");
        drive_dir(32'h0000FFFF, 32'd1, 4'd0, 32'h00010000, 1'b0, 64'd0, "add block carry");
        drive_dir(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2, 32'd1, 1'b0, 64'hFFFFFFFE00000001, "mul max");
        drive_dir(32'h80000000, 32'd4, 4'd12, 32'hF8000000, 1'b0, 64'd0, "sra sign");
        drive_dir(32'hFFFFFFFF, 32'd1, 4'd13, 32'd1, 1'b0, 64'd0, "slt neg");
        drive_dir(32'd1, 32'hFFFFFFFF, 4'd13, 32'd0, 1'b0, 64'd0, "slt pos");
        drive_dir(32'd8, 32'd33, 4'd10, 32'h10, 1'b0, 64'd0, "sll b33");
        drive_dir(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd0, 32'hFFFFFFFE, 1'b1, 64'd0, "add max");

        // Reset between edges clears non-zero outputs at once.
        @(negedge clk);
        compare_head();
        check_val("pre-reset result", {32'd0, result}, 64'hFFFFFFFE);
        #2 rst_n = 1'b0;
        #1;
        check_val("midreset result",  {32'd0, result}, 64'd0);
        check_val("midreset carry",   {63'd0, carry_out}, 64'd0);
        check_val("midreset product", product, 64'd0);
        exp_q.delete();
        @(negedge clk);
        check_val("held reset result", {32'd0, result}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] a, b;
            logic [3:0]  op;
            a  = $urandom();
            b  = $urandom();
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
                0: a = 32'hFFFFFFFF;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h80000000 | a;
                3: b = b & 32'h3F;
                default: ;
            endcase
            drive(a, b, op, model(a, b, op));
        end
        @(negedge clk);
        compare_head();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_1.md
Name: alu_1

Overview:
- 32-bit, 16-operation registered ALU with a 64-bit multiply product output.
- Addition, subtraction and increment use a carry-select adder (CSLA) datapath.
- Sits as the execute-stage arithmetic unit.
- Operands and opcode are sampled every clock; results appear one cycle later.

Parameters:
- WIDTH, 32, operand/result width (product is 2*WIDTH).
- BLOCK, 4, carry-select block size in bits; WIDTH must be a multiple of BLOCK.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- operand1  input  32  operand A.
- operand2  input  32  operand B.
- opcode  input  4  operation select.
- result  output  32  registered ALU result.
- carry_out  output  1  registered carry/borrow flag.
- product  output  64  registered full multiply product.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- rst_n=0 asynchronously clears result, carry_out and product to 0. They are held at 0 while rst_n is low.
- Each rising clk with rst_n=1 registers f(operand1, operand2, opcode).
  - Latency is exactly 1 cycle; throughput is 1 op per cycle.
  - No handshake; every cycle is a new operation.
- Opcode map (A=operand1, B=operand2, all unsigned unless noted):
  - 0 ADD: {carry_out,result}=A+B.
  - 1 SUB: result=A-B; carry_out=1 when A<B unsigned (borrow). Computed as A+~B+1 through the CSLA; carry_out is the inverted adder carry.
  - 2 MUL: product=A*B (64-bit unsigned); result=product[31:0].
  - 3 AND: A&B.
  - 4 OR: A|B.
  - 5 XOR: A^B.
  - 6 NAND: ~(A&B).
  - 7 NOR: ~(A|B).
  - 8 XNOR: ~(A^B).
  - 9 NOT: ~A.
  - 10 SLL: A<<B[4:0].
  - 11 SRL: A>>B[4:0], logical.
  - 12 SRA: A>>>B[4:0], arithmetic (sign of A replicated).
  - 13 SLT: result=32'd1 if $signed(A)<$signed(B), else 0.
  - 14 INC: {carry_out,result}=A+1.
  - 15 PASS: result=A.
- carry_out is 0 for every opcode other than 0, 1 and 14.
- product is 0 for every opcode other than 2.
- Wrap-around:
  - ADD 0xFFFFFFFF+1 -> result 0, carry_out 1.
  - INC 0xFFFFFFFF -> result 0, carry_out 1.
  - SUB 0-1 -> result 0xFFFFFFFF, carry_out 1.
- Shift amounts use only B[4:0]; B[31:5] are ignored.
- No X propagation from unused opcodes: all 16 codes are defined.
- Reset asserted mid-stream overrides any in-flight result. The first valid output is one clk edge after rst_n deasserts with stable inputs.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD=0 … OP_PASS=15;
  - WIDTH default.
- One sub-module, csla_adder:
  - inputs a[WIDTH], b[WIDTH], cin; outputs sum[WIDTH], cout;
  - the first block is a ripple adder;
  - each later BLOCK-bit group has dual ripple adders (cin=0/1) with a mux selected by the previous block's carry.
- Multiply is behavioural (*) in alu_1. Registers and the opcode mux live in alu_1.

Test Plan:
- Reset: hold rst_n=0 with A=8, B=8, op=0 across clocks -> result=0, carry_out=0, product=0. Asserting rst_n between edges clears the outputs immediately.
- Opcode sweep with A=8, B=8, op 0..15, one per clock. Outputs one cycle later:
  - ADD 16, SUB 0 (c=0), MUL 64 (product=64);
  - AND 8, OR 8, XOR 0;
  - NAND 0xFFFFFFF7, NOR 0xFFFFFFF7, XNOR 0xFFFFFFFF, NOT 0xFFFFFFF7;
  - SLL 0x800, SRL 0, SRA 0, SLT 0, INC 9, PASS 8.
- Carry/borrow edges:
  - ADD 0xFFFFFFFF+1 -> 0, c=1.
  - SUB 3-5 -> 0xFFFFFFFE, c=1.
  - INC 0xFFFFFFFF -> 0, c=1.
  - ADD 0x0000FFFF+1 -> 0x00010000, c=0, exercising carry across CSLA blocks.
- Multiply: 0xFFFFFFFF*0xFFFFFFFF -> product=0xFFFFFFFE00000001, result=0x00000001.
- Signed ops:
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - SLT A=0xFFFFFFFF (-1), B=1 -> 1.
  - SLT A=1, B=0xFFFFFFFF -> 0.
  - SLL by B=33 -> shift by 1.
- Random: 1000 random A/B/op vectors compared against a behavioural model with 1-cycle delay. carry_out must be 0 and product 0 whenever op is not ADD/SUB/INC or MUL respectively.
